// File: rtl/apb_xfer_arbiter_if.sv
// apb_xfer_arbiter_if: requester-side and bridge-side signals of the APB transfer arbiter
interface apb_xfer_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   localparam int GW = $clog2(N_REQ);
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        ack;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_err;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [ADDR_W-1:0]       cmd_addr;
   logic [DATA_W-1:0]       cmd_wdata;
   logic                    cmd_done;
   logic [DATA_W-1:0]       cmd_rdata;
   logic                    cmd_abort;
   logic                    busy;
   logic [GW-1:0]           grant_id;
   modport master (
      input  req, req_write, req_addr, req_wdata, cmd_ready, cmd_done, cmd_rdata,
      output ack, rsp_rdata, rsp_err, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
             cmd_abort, busy, grant_id
   );
   modport slave (
      output req, req_write, req_addr, req_wdata, cmd_ready, cmd_done, cmd_rdata,
      input  ack, rsp_rdata, rsp_err, cmd_valid, cmd_write, cmd_addr, cmd_wdata,
             cmd_abort, busy, grant_id
   );
endinterface

// File: rtl/apb_xfer_arbiter.sv
// apb_xfer_arbiter: round-robin sharing of one APB master bridge among N_REQ requesters
module apb_xfer_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input logic                PCLK,
   input logic                PRESET,
   apb_xfer_arbiter_if.master bus
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;
   logic [1:0]    state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] sel;
   logic [GW-1:0] idx;
   logic [CW-1:0] cnt;
   // scan downward so the requester nearest after last_grant is the final winner
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = GW'((int'(last_grant) + k) % N_REQ);
         if (bus.req[idx]) sel = idx;
      end
   end
   // outputs that follow directly from the current state
   always_comb begin
      bus.cmd_valid = state == ISSUE;
      bus.busy      = state != IDLE;
      bus.ack       = (state == RESP) ? (N_REQ'(1) << bus.grant_id) : '0;
   end
   // transfer sequencing: latch winner, hand command to bridge, wait, report back
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state         <= IDLE;
         last_grant    <= GW'(N_REQ - 1);
         cnt           <= '0;
         bus.grant_id  <= '0;
         bus.cmd_write <= 1'b0;
         bus.cmd_addr  <= '0;
         bus.cmd_wdata <= '0;
         bus.cmd_abort <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.cmd_abort <= 1'b0;
         case (state)
            IDLE: if (|bus.req) begin
               state         <= ISSUE;
               bus.grant_id  <= sel;
               bus.cmd_write <= bus.req_write[sel];
               bus.cmd_addr  <= bus.req_addr[sel*ADDR_W +: ADDR_W];
               bus.cmd_wdata <= bus.req_wdata[sel*DATA_W +: DATA_W];
            end
            ISSUE: if (bus.cmd_ready) begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus.cmd_done) begin
                  state         <= RESP;
                  bus.rsp_rdata <= bus.cmd_write ? '0 : bus.cmd_rdata;
                  bus.rsp_err   <= 1'b0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state         <= RESP;
                  bus.cmd_abort <= 1'b1;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b1;
               end
            end
            RESP: begin
               state      <= IDLE;
               last_grant <= bus.grant_id;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// tb_apb_xfer_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_apb_xfer_arbiter;
   localparam int N = 2, AW = 8, DW = 8, TO = 16;
   logic pclk, preset;
   int n_chk = 0, n_pass = 0;
   apb_xfer_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
   apb_xfer_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(pclk), .PRESET(preset), .bus(bus)
   );
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // transaction-level model: which transfer is in flight and how far it has progressed
   bit m_ok = 0, m_xfer, m_acc, m_done, m_abort, m_err, m_write;
   int m_wait, m_last, m_gid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   task automatic model_step();
      if (preset) begin
         m_ok = 1; m_xfer = 0; m_acc = 0; m_done = 0; m_abort = 0; m_err = 0; m_write = 0;
         m_wait = 0; m_last = N - 1; m_gid = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
      end else if (m_ok) begin
         m_abort = 0;
         if (m_done) begin
            m_xfer = 0; m_done = 0; m_last = m_gid;
         end else if (!m_xfer) begin
            for (int k = 1; k <= N; k++) begin
               int i = (m_last + k) % N;
               if (bus.req[i]) begin
                  m_xfer = 1; m_acc = 0; m_gid = i;
                  m_write = bus.req_write[i];
                  m_addr = bus.req_addr[i*AW +: AW];
                  m_wdata = bus.req_wdata[i*DW +: DW];
                  break;
               end
            end
         end else if (!m_acc) begin
            if (bus.cmd_ready) begin m_acc = 1; m_wait = 0; end
         end else if (bus.cmd_done) begin
            m_rdata = m_write ? '0 : bus.cmd_rdata; m_err = 0; m_done = 1;
         end else if (m_wait == TO - 1) begin
            m_abort = 1; m_rdata = 0; m_err = 1; m_done = 1;
         end else m_wait++;
      end
   endtask

   // compare every cycle on the falling edge, then advance the model with the inputs the next edge will see
   initial forever begin
      @(negedge pclk);
      if (m_ok) begin
         chk("busy", bus.busy, m_xfer);
         chk("cmd_valid", bus.cmd_valid, m_xfer && !m_acc);
         chk("ack", bus.ack, m_done ? (1 << m_gid) : 0);
         chk("cmd_abort", bus.cmd_abort, m_abort);
         chk("rsp_rdata", bus.rsp_rdata, m_rdata);
         chk("rsp_err", bus.rsp_err, m_err);
         chk("cmd_write", bus.cmd_write, m_write);
         chk("cmd_addr", bus.cmd_addr, m_addr);
         chk("cmd_wdata", bus.cmd_wdata, m_wdata);
         chk("grant_id", bus.grant_id, m_gid);
      end
      model_step();
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge pclk);
      #2;
   endtask

   task automatic wait_ack(input string name, output int n);
      n = 0;
      while (bus.ack == 0 && n < 64) begin cyc(); n++; end
      chk(name, bus.ack != 0, 1);
   endtask

   task automatic rand_inputs();
      preset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
         if (bus.req[i] && bus.ack[i]) begin
            if ($urandom_range(0, 7) != 0) bus.req[i] = 1'b0;
         end else if (!bus.req[i]) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.req[i] = 1'b1;
               bus.req_write[i] = 1'($urandom_range(0, 1));
               bus.req_addr[i*AW +: AW] = AW'($urandom);
               bus.req_wdata[i*DW +: DW] = DW'($urandom);
            end
         end else if ($urandom_range(0, 31) == 0) bus.req[i] = 1'b0;
         if ($urandom_range(0, 5) == 0) begin
            bus.req_addr[i*AW +: AW] = AW'($urandom);
            bus.req_wdata[i*DW +: DW] = DW'($urandom);
         end
      end
      bus.cmd_ready = 1'($urandom_range(0, 1));
      bus.cmd_done = ($urandom_range(0, 9) == 0);
      bus.cmd_rdata = DW'($urandom);
   endtask

   initial begin
      int n;
      preset = 1'b1;
      bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_rdata = '0;
      repeat (3) cyc();
      // reset values
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.cmd_valid, 0);
      chk("rst_ack", bus.ack, 0);
      chk("rst_grant", bus.grant_id, 0);
      chk("rst_addr", bus.cmd_addr, 0);
      chk("rst_abort", bus.cmd_abort, 0);
      chk("rst_rsp", {bus.rsp_err, bus.rsp_rdata}, 0);
      // single read
      preset = 1'b0;
      bus.req = 2'b01; bus.req_write = 2'b00; bus.req_addr = 16'h0012;
      cyc();
      chk("sr_valid", bus.cmd_valid, 1);
      chk("sr_addr", bus.cmd_addr, 'h12);
      chk("sr_write", bus.cmd_write, 0);
      bus.cmd_ready = 1'b1; cyc(); bus.cmd_ready = 1'b0;
      chk("sr_valid_low", bus.cmd_valid, 0);
      cyc(); cyc();
      bus.cmd_done = 1'b1; bus.cmd_rdata = 8'hA5; cyc(); bus.cmd_done = 1'b0; bus.cmd_rdata = '0;
      chk("sr_ack", bus.ack, 2'b01);
      chk("sr_rdata", bus.rsp_rdata, 'hA5);
      chk("sr_err", bus.rsp_err, 0);
      bus.req = '0; cyc();
      chk("sr_ack_pulse", bus.ack, 0);
      chk("sr_idle", bus.busy, 0);
      // timeout on a write; req dropped after latch must not cancel
      bus.req = 2'b01; bus.req_write = 2'b01; bus.req_wdata = 16'h0044;
      cyc();
      bus.cmd_ready = 1'b1; cyc(); bus.cmd_ready = 1'b0;
      bus.req = '0;
      n = 0;
      while (!bus.cmd_abort && n < 40) begin cyc(); n++; end
      chk("to_abort_delay", n, TO);
      chk("to_ack", bus.ack, 2'b01);
      chk("to_err", bus.rsp_err, 1);
      chk("to_rdata", bus.rsp_rdata, 0);
      cyc();
      chk("to_abort_pulse", bus.cmd_abort, 0);
      chk("to_idle", bus.busy, 0);
      // done coincides with the last timeout cycle: done wins
      bus.req = 2'b01; bus.req_write = 2'b00; bus.req_addr = 16'h0021;
      cyc();
      bus.cmd_ready = 1'b1; cyc(); bus.cmd_ready = 1'b0;
      bus.req = '0;
      repeat (TO - 1) cyc();
      chk("sim_pre_abort", bus.cmd_abort, 0);
      chk("sim_pre_ack", bus.ack, 0);
      bus.cmd_done = 1'b1; bus.cmd_rdata = 8'h5A; cyc(); bus.cmd_done = 1'b0;
      chk("sim_ack", bus.ack, 2'b01);
      chk("sim_err", bus.rsp_err, 0);
      chk("sim_abort", bus.cmd_abort, 0);
      chk("sim_rdata", bus.rsp_rdata, 'h5A);
      cyc();
      // backpressure with changing address
      bus.req = 2'b01; bus.req_write = 2'b01; bus.req_addr = 16'h0030; bus.req_wdata = 16'h0099;
      cyc();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", bus.cmd_valid, 1);
         chk("bp_addr", bus.cmd_addr, 'h30);
         bus.req_addr[AW-1:0] = AW'(8'h31 + k);
         cyc();
      end
      bus.cmd_ready = 1'b1; cyc(); bus.cmd_ready = 1'b0;
      chk("bp_wait", bus.cmd_valid, 0);
      chk("bp_busy", bus.busy, 1);
      bus.cmd_done = 1'b1; cyc(); bus.cmd_done = 1'b0;
      chk("bp_ack", bus.ack, 2'b01);
      chk("bp_wdata", bus.cmd_wdata, 'h99);
      bus.req = '0; cyc();
      // reset mid-transfer after requester 0 was last served
      bus.req = 2'b10; bus.req_addr = 16'h5500;
      cyc();
      bus.cmd_ready = 1'b1; cyc(); bus.cmd_ready = 1'b0;
      chk("rm_grant1", bus.grant_id, 1);
      preset = 1'b1; cyc();
      chk("rm_busy", bus.busy, 0);
      chk("rm_ack", bus.ack, 0);
      chk("rm_grant", bus.grant_id, 0);
      chk("rm_addr", bus.cmd_addr, 0);
      preset = 1'b0; bus.req = 2'b11; cyc();
      chk("rm_first", bus.grant_id, 0);
      chk("rm_valid", bus.cmd_valid, 1);
      bus.req = '0; bus.cmd_ready = 1'b1; bus.cmd_done = 1'b1;
      wait_ack("rm_ack_seen", n);
      bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; cyc();
      // contention from reset: grants alternate
      preset = 1'b1; repeat (2) cyc();
      preset = 1'b0; bus.req = 2'b11; bus.req_write = 2'b11; bus.req_wdata = 16'hC33C;
      bus.cmd_ready = 1'b1; bus.cmd_done = 1'b1;
      for (int g = 0; g < 4; g++) begin
         wait_ack("ct_ack_seen", n);
         chk("ct_grant", bus.grant_id, g % 2);
         chk("ct_ack", bus.ack, 1 << (g % 2));
         chk("ct_wdata", bus.cmd_wdata, (g % 2) ? 'hC3 : 'h3C);
         cyc();
         chk("ct_ack_pulse", bus.ack, 0);
      end
      bus.req = '0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;
      cyc(); cyc();
      // randomized traffic, including occasional resets
      for (int c = 0; c < 3000; c++) begin
         cyc();
         rand_inputs();
      end
      preset = 1'b0; bus.req = '0;
      repeat (3) cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/apb_xfer_arbiter.md
Name: apb_xfer_arbiter

Overview:
- Shares the single APB master bridge between N_REQ independent requesters (e.g. UART host path and GPIO host path).
- Arbitrates round-robin and latches the winner's command. Issues exactly one APB transfer command to the bridge, waits for completion or timeout, then returns read data and status to the winner.
- Sits directly upstream of the APB master bridge; the bridge remains the only block driving APB signals.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, transfer address width (matches APB PADDR).
- DATA_W, 8, transfer data width (matches PWDATA/PRDATA).
- TIMEOUT, 16, max cycles in WAIT before abort (>=2).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request level; held until matching ack.
- req_write  in  N_REQ  1=write, 0=read, per requester.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data, same packing.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_W  read data, valid while ack!=0.
- rsp_err  out  1  timeout error, valid while ack!=0.
- cmd_valid  out  1  command to bridge valid.
- cmd_ready  in  1  bridge accepts command.
- cmd_write  out  1  latched direction.
- cmd_addr  out  ADDR_W  latched address.
- cmd_wdata  out  DATA_W  latched write data.
- cmd_done  in  1  bridge transfer complete (PREADY seen in ACCESS).
- cmd_rdata  in  DATA_W  bridge read data, valid with cmd_done.
- cmd_abort  out  1  one-cycle pulse telling bridge to return to IDLE.
- busy  out  1  high in any state except IDLE.
- grant_id  out  clog2(N_REQ)  index of current/last granted requester.

Behaviour:
- Reset (PRESET=1 at edge), all outputs and state:
  - state=IDLE; ack=0, rsp_rdata=0, rsp_err=0.
  - cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, cmd_abort=0.
  - busy=0, grant_id=0; internal last_grant=N_REQ-1, so requester 0 has first priority; timeout counter=0.
  - Reset mid-transfer discards the transfer; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo N_REQ.
  - Latch that requester's write/addr/wdata into cmd_* and set grant_id.
  - Next state ISSUE. No req: stay.
- ISSUE:
  - cmd_valid=1, held with cmd_* stable until cmd_ready=1; that same cycle's edge moves to WAIT with cmd_valid=0 and counter cleared.
  - ISSUE has no timeout.
- WAIT:
  - Counter increments each cycle.
  - cmd_done=1: capture cmd_rdata (writes capture 0), rsp_err=0, go RESP.
  - Counter reaches TIMEOUT-1 without cmd_done: cmd_abort pulses for one cycle, rsp_rdata=0, rsp_err=1, go RESP.
  - cmd_done and timeout in the same cycle: cmd_done wins, no abort.
- RESP:
  - ack[grant_id]=1 for exactly one cycle with rsp_rdata/rsp_err.
  - last_grant<=grant_id; next state IDLE. rsp_* hold their values until the next RESP.
- Latency: req rising (IDLE) to cmd_valid is 1 cycle. cmd_done to ack is 1 cycle. The minimum gap between back-to-back grants is 1 IDLE cycle.
- Requests are sampled only in IDLE.
  - A req dropped after latch does not cancel the transfer; ack still pulses.
  - Requester inputs changing after latch are ignored.
- A requester must drop req the cycle after ack, or it re-enters arbitration at lowest priority.
- cmd_done or cmd_ready outside ISSUE/WAIT is ignored.

Test Plan:
- Single read: req=2'b01, addr0=0x12, write0=0; cmd_ready=1 on cycle 2; cmd_done with cmd_rdata=0xA5 three cycles later -> cmd_addr=0x12, cmd_write=0, ack=2'b01 one cycle, rsp_rdata=0xA5, rsp_err=0.
- Contention: req=2'b11 held from reset -> grants alternate 0,1,0,1 (grant_id). Each ack is a single cycle, and each requester's wdata appears on cmd_wdata during its own grant.
- Timeout: write, cmd_ready=1, cmd_done never asserted -> cmd_abort pulse exactly TIMEOUT cycles after entering WAIT. Then ack with rsp_err=1, rsp_rdata=0, state back to IDLE.
- Simultaneous: cmd_done asserted on the cycle the counter hits TIMEOUT-1 -> rsp_err=0, no cmd_abort, rdata captured.
- Backpressure/stability: cmd_ready low for 5 cycles while req_addr changes -> cmd_valid stays high and cmd_addr holds the latched value; WAIT is entered only after cmd_ready=1.
- Reset mid-transfer: PRESET=1 in WAIT -> next cycle all outputs at reset values, no ack. After release with req=2'b11, requester 0 is granted first.
